// File: rtl/axi_s0_wr_initiator_if.sv
// AXI write-channel bundle (AW, W, B) between the slave-0 write initiator and the NOC slave port.
interface axi_s0_wr_initiator_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 8
);
    logic [ID_W-1:0]     AWID;
    logic [ADDR_W-1:0]   AWADDR;
    logic [3:0]          AWLEN;
    logic [2:0]          AWSIZE;
    logic [1:0]          AWBURST;
    logic                AWVALID;
    logic                AWREADY;

    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WLAST;
    logic                WVALID;
    logic                WREADY;

    logic [ID_W-1:0]     BID;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );
endinterface

// File: rtl/axi_s0_wr_initiator.sv
// AXI write initiator for the slave-0 path: one burst at a time, AW then W beats then B,
// with response/ID checking and an optional B-channel timeout.
module axi_s0_wr_initiator #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ID_W    = 8,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                  ACLK,
    input  logic                  ASW_RESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [3:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic [1:0]            cmd_burst,
    input  logic [ID_W-1:0]       cmd_id,
    input  logic                  wd_valid,
    output logic                  wd_ready,
    input  logic [DATA_W-1:0]     wd_data,
    input  logic [DATA_W/8-1:0]   wd_strb,
    axi_s0_wr_initiator_if.master m_axi,
    output logic                  done,
    output logic [1:0]            done_resp,
    output logic                  err
);

    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    awid_q, awid_d;
    logic [ADDR_W-1:0]  awaddr_q, awaddr_d;
    logic [3:0]         awlen_q, awlen_d;
    logic [2:0]         awsize_q, awsize_d;
    logic [1:0]         awburst_q, awburst_d;
    logic [3:0]         beat_q, beat_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               done_q, done_d;
    logic [1:0]         resp_q, resp_d;
    logic               err_q, err_d;

    logic               in_data;
    logic               last_beat;
    logic               beat_fire;

    assign in_data   = (state_q == ST_DATA);
    assign last_beat = (beat_q == awlen_q);
    assign beat_fire = in_data && wd_valid && m_axi.WREADY;

    // State and payload registers.
    always_ff @(posedge ACLK) begin
        if (ASW_RESET) begin
            state_q   <= ST_IDLE;
            awid_q    <= '0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awsize_q  <= '0;
            awburst_q <= '0;
            beat_q    <= '0;
            tmo_q     <= '0;
            done_q    <= 1'b0;
            resp_q    <= RESP_OKAY;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            awid_q    <= awid_d;
            awaddr_q  <= awaddr_d;
            awlen_q   <= awlen_d;
            awsize_q  <= awsize_d;
            awburst_q <= awburst_d;
            beat_q    <= beat_d;
            tmo_q     <= tmo_d;
            done_q    <= done_d;
            resp_q    <= resp_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic: AW, then W beats up to AWLEN, then wait for B or timeout.
    always_comb begin
        state_d   = state_q;
        awid_d    = awid_q;
        awaddr_d  = awaddr_q;
        awlen_d   = awlen_q;
        awsize_d  = awsize_q;
        awburst_d = awburst_q;
        beat_d    = beat_q;
        tmo_d     = tmo_q;
        done_d    = 1'b0;
        resp_d    = resp_q;
        err_d     = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    awid_d    = cmd_id;
                    awaddr_d  = cmd_addr;
                    awlen_d   = cmd_len;
                    awsize_d  = cmd_size;
                    awburst_d = cmd_burst;
                    beat_d    = '0;
                    tmo_d     = '0;
                    state_d   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (m_axi.AWREADY) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (beat_fire) begin
                    if (last_beat) begin
                        beat_d  = '0;
                        tmo_d   = '0;
                        state_d = ST_RESP;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            ST_RESP: begin
                // A response arriving on the expiry cycle takes priority over the timeout.
                if (m_axi.BVALID) begin
                    resp_d  = m_axi.BRESP;
                    err_d   = err_q || (m_axi.BRESP != RESP_OKAY) || (m_axi.BID != awid_q);
                    done_d  = 1'b1;
                    tmo_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if ((TIMEOUT != 0) && (tmo_d == TMO_LIM)) begin
                        resp_d  = RESP_SLVERR;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        tmo_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready      = (state_q == ST_IDLE);

    assign m_axi.AWID     = awid_q;
    assign m_axi.AWADDR   = awaddr_q;
    assign m_axi.AWLEN    = awlen_q;
    assign m_axi.AWSIZE   = awsize_q;
    assign m_axi.AWBURST  = awburst_q;
    assign m_axi.AWVALID  = (state_q == ST_ADDR);

    // W channel is a gated pass-through of the client beat stream.
    assign m_axi.WDATA    = wd_data;
    assign m_axi.WSTRB    = wd_strb;
    assign m_axi.WVALID   = in_data && wd_valid;
    assign m_axi.WLAST    = in_data && last_beat;
    assign wd_ready       = in_data && m_axi.WREADY;

    assign m_axi.BREADY   = (state_q == ST_RESP);

    assign done           = done_q;
    assign done_resp      = resp_q;
    assign err            = err_q;

endmodule

// File: tb/tb_axi_s0_wr_initiator.sv
// Directed bench for axi_s0_wr_initiator: single/16-beat bursts, AW backpressure,
// response/ID errors, timeout, BVALID-vs-timeout priority and mid-burst reset.
module tb_axi_s0_wr_initiator;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned IW  = 8;
    localparam int unsigned TMO = 8;

    logic          ACLK = 1'b0;
    logic          ASW_RESET;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [3:0]    cmd_len;
    logic [2:0]    cmd_size;
    logic [1:0]    cmd_burst;
    logic [IW-1:0] cmd_id;
    logic          wd_valid;
    logic          wd_ready;
    logic [DW-1:0] wd_data;
    logic [DW/8-1:0] wd_strb;
    logic          done;
    logic [1:0]    done_resp;
    logic          err;

    int checks = 0;
    int errors = 0;

    axi_s0_wr_initiator_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) ax ();

    axi_s0_wr_initiator #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .TIMEOUT(TMO)) dut (
        .ACLK      (ACLK),
        .ASW_RESET (ASW_RESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_size  (cmd_size),
        .cmd_burst (cmd_burst),
        .cmd_id    (cmd_id),
        .wd_valid  (wd_valid),
        .wd_ready  (wd_ready),
        .wd_data   (wd_data),
        .wd_strb   (wd_strb),
        .m_axi     (ax),
        .done      (done),
        .done_resp (done_resp),
        .err       (err)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present a command in IDLE; returns one cycle later with the DUT in ADDR.
    task automatic send_cmd(input logic [31:0] a, input logic [3:0] l, input logic [7:0] id);
        chk("cmd_ready", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
        cmd_size = 3'd2; cmd_burst = 2'b01; cmd_id = id;
        @(negedge ACLK);
        cmd_valid = 1'b0;
        chk("aw_id_addr", {24'd0, ax.AWID, ax.AWADDR}, {24'd0, id, a});
        chk("aw_len", 64'(ax.AWLEN), 64'(l));
        chk("aw_size_burst", 64'({ax.AWSIZE, ax.AWBURST}), 64'({3'd2, 2'b01}));
    endtask

    task automatic aw_accept();
        ax.AWREADY = 1'b1;
        #1;
        chk("awvalid", 64'(ax.AWVALID), 64'd1);
        @(negedge ACLK);
        ax.AWREADY = 1'b0;
        chk("awvalid_drop", 64'(ax.AWVALID), 64'd0);
    endtask

    // Stream n beats; WREADY optionally toggles 1/0. Returns with the DUT in RESP.
    task automatic send_beats(input int n, input bit toggle, input logic [31:0] base);
        int idx = 0;
        int guard = 0;
        logic hs;
        while (idx < n && guard < 4 * n + 8) begin
            ax.WREADY = toggle ? ((guard % 2) == 0) : 1'b1;
            wd_valid  = 1'b1;
            wd_data   = base + 32'(idx);
            wd_strb   = 4'hF ^ 4'(idx);
            #1;
            chk("wvalid", 64'(ax.WVALID), 64'd1);
            chk("wlast", 64'(ax.WLAST), 64'(idx == n - 1));
            chk("wdata", 64'(ax.WDATA), 64'(base + 32'(idx)));
            chk("wstrb", 64'(ax.WSTRB), 64'(4'hF ^ 4'(idx)));
            chk("wd_ready", 64'(wd_ready), 64'(ax.WREADY));
            hs = ax.WREADY;
            @(negedge ACLK);
            if (hs) idx++;
            guard++;
        end
        chk("beats_sent", 64'(idx), 64'(n));
        wd_valid  = 1'b0;
        ax.WREADY = 1'b0;
    endtask

    // Hold BVALID off for 'delay' RESP cycles, then respond; returns on the done cycle.
    task automatic respond(input logic [1:0] r, input logic [7:0] id, input int delay);
        for (int i = 0; i < delay; i++) begin
            chk("bready_wait", 64'(ax.BREADY), 64'd1);
            @(negedge ACLK);
        end
        ax.BVALID = 1'b1; ax.BRESP = r; ax.BID = id;
        chk("bready", 64'(ax.BREADY), 64'd1);
        @(negedge ACLK);
        ax.BVALID = 1'b0;
        chk("done", 64'(done), 64'd1);
        chk("bready_low", 64'(ax.BREADY), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        ASW_RESET = 1'b1;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
        cmd_burst = '0; cmd_id = '0;
        wd_valid = 1'b1; wd_data = '0; wd_strb = '0;
        ax.AWREADY = 1'b0; ax.WREADY = 1'b0;
        ax.BID = '0; ax.BRESP = '0; ax.BVALID = 1'b0;
        repeat (2) @(negedge ACLK);

        // Reset values.
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_awvalid", 64'(ax.AWVALID), 64'd0);
        chk("rst_wvalid", 64'(ax.WVALID), 64'd0);
        chk("rst_bready", 64'(ax.BREADY), 64'd0);
        chk("rst_wlast", 64'(ax.WLAST), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_resp", 64'(done_resp), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        ASW_RESET = 1'b0;
        wd_valid  = 1'b0;

        // Single-beat burst.
        send_cmd(32'h100, 4'd0, 8'h05);
        aw_accept();
        send_beats(1, 1'b0, 32'hA5A5_0000);
        respond(2'b00, 8'h05, 0);
        chk("single_resp", 64'(done_resp), 64'd0);
        chk("single_err", 64'(err), 64'd0);
        @(negedge ACLK);
        chk("done_pulse", 64'(done), 64'd0);

        // AW backpressure: AWVALID held with stable payload, W gated off.
        send_cmd(32'h2000, 4'd1, 8'h11);
        wd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_awvalid", 64'(ax.AWVALID), 64'd1);
            chk("bp_awaddr", 64'(ax.AWADDR), 64'h2000);
            chk("bp_awlen", 64'(ax.AWLEN), 64'd1);
            chk("bp_wvalid", 64'(ax.WVALID), 64'd0);
            @(negedge ACLK);
        end
        wd_valid = 1'b0;
        aw_accept();
        send_beats(2, 1'b0, 32'hB000_0000);
        respond(2'b00, 8'h11, 2);
        chk("bp_resp", 64'(done_resp), 64'd0);

        // 16-beat burst with WREADY toggling; new command accepted on the done cycle.
        send_cmd(32'h3000, 4'd15, 8'h22);
        aw_accept();
        send_beats(16, 1'b1, 32'hC000_0000);
        respond(2'b00, 8'h22, 0);
        chk("b16_resp", 64'(done_resp), 64'd0);
        chk("b16_err", 64'(err), 64'd0);

        // Timeout: no BVALID, expect exactly TMO cycles with BREADY high.
        send_cmd(32'h4000, 4'd0, 8'h33);
        aw_accept();
        send_beats(1, 1'b0, 32'hD000_0000);
        k = 0;
        while (ax.BREADY === 1'b1 && k < 20) begin
            k++;
            @(negedge ACLK);
        end
        chk("tmo_cycles", 64'(k), 64'd8);
        chk("tmo_done", 64'(done), 64'd1);
        chk("tmo_resp", 64'(done_resp), 64'd2);
        chk("tmo_err", 64'(err), 64'd1);

        // Reset after beat 3 of 8 abandons the burst and clears sticky state.
        send_cmd(32'h5000, 4'd7, 8'h44);
        aw_accept();
        wd_valid = 1'b1; ax.WREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wd_data = 32'hE000_0000 + 32'(i);
            #1;
            chk("mid_wlast", 64'(ax.WLAST), 64'd0);
            @(negedge ACLK);
        end
        ASW_RESET = 1'b1;
        @(negedge ACLK);
        chk("mr_wvalid", 64'(ax.WVALID), 64'd0);
        chk("mr_wd_ready", 64'(wd_ready), 64'd0);
        chk("mr_wlast", 64'(ax.WLAST), 64'd0);
        chk("mr_awvalid", 64'(ax.AWVALID), 64'd0);
        chk("mr_bready", 64'(ax.BREADY), 64'd0);
        chk("mr_done", 64'(done), 64'd0);
        chk("mr_resp", 64'(done_resp), 64'd0);
        chk("mr_err", 64'(err), 64'd0);
        ASW_RESET = 1'b0; wd_valid = 1'b0; ax.WREADY = 1'b0;

        // BID mismatch flags err with an OKAY response.
        send_cmd(32'h6000, 4'd2, 8'h05);
        aw_accept();
        send_beats(3, 1'b0, 32'hF000_0000);
        respond(2'b00, 8'h06, 1);
        chk("bid_resp", 64'(done_resp), 64'd0);
        chk("bid_err", 64'(err), 64'd1);

        // err stays set across a clean transaction.
        send_cmd(32'h7000, 4'd0, 8'h07);
        aw_accept();
        send_beats(1, 1'b0, 32'h1234_0000);
        respond(2'b00, 8'h07, 0);
        chk("sticky_resp", 64'(done_resp), 64'd0);
        chk("sticky_err", 64'(err), 64'd1);

        // SLVERR response is reported verbatim.
        send_cmd(32'h8000, 4'd0, 8'h05);
        aw_accept();
        send_beats(1, 1'b0, 32'h5678_0000);
        respond(2'b10, 8'h05, 0);
        chk("slverr_resp", 64'(done_resp), 64'd2);

        // BVALID on the expiry cycle wins over the timeout.
        send_cmd(32'h9000, 4'd0, 8'h09);
        aw_accept();
        send_beats(1, 1'b0, 32'h9ABC_0000);
        respond(2'b01, 8'h09, 7);
        chk("tie_resp", 64'(done_resp), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
